// File: rtl/mesa_pkg.sv
// Shared constants for the MesaBus byte-to-ASCII stage.
package mesa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HI      = 3'd1,
    ST_HI_GAP  = 3'd2,
    ST_LO      = 3'd3,
    ST_LO_GAP  = 3'd4,
    ST_EOL     = 3'd5,
    ST_EOL_GAP = 3'd6
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/mesa_nib2hex.sv
// Nibble to ASCII hex digit, combinational.
module mesa_nib2hex
  import mesa_pkg::*;
(
  input  logic       upper,
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  // Digits map from '0'; letters map from 'A' or 'a' offset by ten.
  always_comb begin
    ascii = ASCII_0 + {4'h0, nib};
    if (nib > 4'd9)
      ascii = (upper ? ASCII_UA : ASCII_LA) + {4'h0, nib - 4'd10};
  end

endmodule

// File: rtl/mesa_byte2ascii.sv
// Serializes Ro bytes as two ASCII hex chars (high nibble first) plus
// an optional end-of-line, handshaking with the UART via tx_busy.
module mesa_byte2ascii
  import mesa_pkg::*;
#(
  parameter bit         UPPER_CASE = 1'b1,
  parameter logic [7:0] EOL_CHAR   = ASCII_LF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ro_byte_d,
  input  logic       ro_byte_en,
  input  logic       ro_done,
  output logic       ro_busy,
  output logic [7:0] tx_char_d,
  output logic       tx_char_en,
  input  logic       tx_busy,
  output logic       ro_overflow
);

  state_t     state, state_nxt;
  logic [7:0] byte_q, byte_nxt;
  logic       eol_pend, eol_nxt;
  logic       ovf_nxt;
  logic [7:0] txd_nxt;
  logic       txen_nxt;
  logic [3:0] nib;
  logic [7:0] hex;

  // One shared converter; the held byte's nibble is picked by state.
  assign nib = (state == ST_LO) ? byte_q[3:0] : byte_q[7:4];

  mesa_nib2hex u_nib2hex (
    .upper (UPPER_CASE),
    .nib   (nib),
    .ascii (hex)
  );

  // Next-state and next-output decode; all outputs leave through flops.
  always_comb begin
    state_nxt = state;
    byte_nxt  = byte_q;
    eol_nxt   = eol_pend | (ro_done & (state != ST_IDLE));
    ovf_nxt   = ro_overflow | (ro_byte_en & (state != ST_IDLE));
    txd_nxt   = tx_char_d;
    txen_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ro_byte_en) begin
          byte_nxt  = ro_byte_d;
          eol_nxt   = ro_done;
          state_nxt = ST_HI;
        end else if (ro_done) begin
          state_nxt = ST_EOL;
        end
      end
      ST_HI: begin
        if (!tx_busy) begin
          txen_nxt  = 1'b1;
          txd_nxt   = hex;
          state_nxt = ST_HI_GAP;
        end
      end
      // Gap states give the UART a cycle to raise tx_busy.
      ST_HI_GAP: state_nxt = ST_LO;
      ST_LO: begin
        if (!tx_busy) begin
          txen_nxt  = 1'b1;
          txd_nxt   = hex;
          state_nxt = ST_LO_GAP;
        end
      end
      ST_LO_GAP: state_nxt = (eol_pend | ro_done) ? ST_EOL : ST_IDLE;
      ST_EOL: begin
        if (!tx_busy) begin
          txen_nxt  = 1'b1;
          txd_nxt   = EOL_CHAR;
          state_nxt = ST_EOL_GAP;
        end
      end
      ST_EOL_GAP: begin
        eol_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any byte in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      byte_q      <= 8'h00;
      eol_pend    <= 1'b0;
      ro_busy     <= 1'b0;
      tx_char_d   <= 8'h00;
      tx_char_en  <= 1'b0;
      ro_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      byte_q      <= byte_nxt;
      eol_pend    <= eol_nxt;
      ro_busy     <= (state_nxt != ST_IDLE);
      tx_char_d   <= txd_nxt;
      tx_char_en  <= txen_nxt;
      ro_overflow <= ovf_nxt;
    end
  end

endmodule
